// File: rtl/gradient_pkg.sv
// Shared definitions for the gradient test-card checker: reference base
// colours, default raster size and the checker state encoding.
package gradient_pkg;

    localparam int DEFAULT_H_RES = 64;
    localparam int DEFAULT_V_RES = 256;

    localparam logic [7:0] BASE_RED   = 8'h00;
    localparam logic [7:0] BASE_GREEN = 8'h10;
    localparam logic [7:0] BASE_BLUE  = 8'h4C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // One gradient channel: base colour plus a per-pixel offset, wrapping mod 256.
    function automatic logic [7:0] gradient_channel(input logic [7:0] base,
                                                    input logic [7:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/gradient_expect.sv
// Reference colour generator: the pixel value the test card should carry at
// position (x, y). Purely combinational.
module gradient_expect
    import gradient_pkg::*;
(
    input  logic [5:0] x_i,
    input  logic [7:0] y_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o
);

    // Red ramps along both axes, green and blue only down the frame.
    always_comb begin
        red_o   = gradient_channel(BASE_RED, y_i + {2'b00, x_i});
        green_o = gradient_channel(BASE_GREEN, y_i);
        blue_o  = gradient_channel(BASE_BLUE, y_i);
    end

endmodule

// File: rtl/test_card_gradient_checker.sv
// Gradient test-card checker: walks a raster position with each accepted
// beat, compares the received colour with the reference gradient, counts
// mismatches and reports a per-frame pass/fail verdict.
module test_card_gradient_checker
    import gradient_pkg::*;
#(
    parameter int H_RES = DEFAULT_H_RES,
    parameter int V_RES = DEFAULT_V_RES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic        o_ready,
    output logic        o_mismatch,
    output logic        o_sync_err,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [15:0] o_err_count,
    output logic [5:0]  o_first_err_x,
    output logic [7:0]  o_first_err_y
);

    localparam logic [5:0] X_LAST = 6'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [15:0] errCount_q, errCount_d;
    logic [5:0]  firstX_q, firstX_d;
    logic [7:0]  firstY_q, firstY_d;
    logic        frameOk_q, frameOk_d;
    logic        frameResult_q, frameResult_d;
    logic        mismatch_q, mismatch_d;
    logic        syncErr_q, syncErr_d;
    logic        frameDone_q, frameDone_d;

    logic        beatAccept;
    logic        beatChecked;
    logic        beatBad;
    logic        beatLast;
    logic [5:0]  checkX;
    logic [7:0]  checkY;
    logic [7:0]  expRed, expGreen, expBlue;

    // The only cycle that refuses beats is the single REPORT cycle.
    assign o_ready    = (state_q != ST_REPORT);
    assign beatAccept = i_valid && o_ready;

    // A start-of-frame beat is always judged as pixel (0,0), whatever the walk says.
    assign checkX = i_sof ? 6'd0 : x_q;
    assign checkY = i_sof ? 8'd0 : y_q;

    gradient_expect u_expect (
        .x_i     (checkX),
        .y_i     (checkY),
        .red_o   (expRed),
        .green_o (expGreen),
        .blue_o  (expBlue)
    );

    assign beatBad  = (i_red != expRed) || (i_green != expGreen) || (i_blue != expBlue);
    assign beatLast = (checkX == X_LAST) && (checkY == Y_LAST);

    // Next-state logic: frame tracking, error bookkeeping and position walk.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        errCount_d    = errCount_q;
        firstX_d      = firstX_q;
        firstY_d      = firstY_q;
        frameOk_d     = frameOk_q;
        frameResult_d = frameResult_q;
        mismatch_d    = 1'b0;
        syncErr_d     = 1'b0;
        frameDone_d   = 1'b0;
        beatChecked   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beatAccept && i_sof) begin
                    beatChecked = 1'b1;
                    errCount_d  = 16'd0;
                    firstX_d    = 6'd0;
                    firstY_d    = 8'd0;
                    frameOk_d   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (beatAccept) begin
                    beatChecked = 1'b1;
                    if (i_sof) begin
                        syncErr_d = 1'b1;
                        frameOk_d = 1'b0;
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
                x_d     = 6'd0;
                y_d     = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = 6'd0;
                y_d     = 8'd0;
            end
        endcase

        if (beatChecked) begin
            if (beatBad) begin
                mismatch_d = 1'b1;
                frameOk_d  = 1'b0;
                if (errCount_d == 16'd0) begin
                    firstX_d = checkX;
                    firstY_d = checkY;
                end
                if (errCount_d != 16'hFFFF) begin
                    errCount_d = errCount_d + 16'd1;
                end
            end

            if (beatLast) begin
                state_d       = ST_REPORT;
                x_d           = 6'd0;
                y_d           = 8'd0;
                frameDone_d   = 1'b1;
                frameResult_d = frameOk_d;
            end else if (checkX == X_LAST) begin
                state_d = ST_CHECK;
                x_d     = 6'd0;
                y_d     = checkY + 8'd1;
            end else begin
                state_d = ST_CHECK;
                x_d     = checkX + 6'd1;
                y_d     = checkY;
            end
        end
    end

    // State registers; reset wins over any beat presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            x_q           <= 6'd0;
            y_q           <= 8'd0;
            errCount_q    <= 16'd0;
            firstX_q      <= 6'd0;
            firstY_q      <= 8'd0;
            frameOk_q     <= 1'b0;
            frameResult_q <= 1'b0;
            mismatch_q    <= 1'b0;
            syncErr_q     <= 1'b0;
            frameDone_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            errCount_q    <= errCount_d;
            firstX_q      <= firstX_d;
            firstY_q      <= firstY_d;
            frameOk_q     <= frameOk_d;
            frameResult_q <= frameResult_d;
            mismatch_q    <= mismatch_d;
            syncErr_q     <= syncErr_d;
            frameDone_q   <= frameDone_d;
        end
    end

    assign o_mismatch    = mismatch_q;
    assign o_sync_err    = syncErr_q;
    assign o_frame_done  = frameDone_q;
    assign o_frame_ok    = frameResult_q;
    assign o_err_count   = errCount_q;
    assign o_first_err_x = firstX_q;
    assign o_first_err_y = firstY_q;

endmodule

// File: tb/tb_test_card_gradient_checker.sv
// Self-checking bench for test_card_gradient_checker. A behavioural model
// written against a linear pixel index predicts every output for the cycle
// after each edge; predictions queue up and are compared one cycle later.
module tb_test_card_gradient_checker;

    localparam int H     = 64;
    localparam int V     = 256;
    localparam int FRAME = H * V;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        sof;
    logic [7:0]  red, green, blue;
    logic        ready, mismatch, syncErr, frameDone, frameOk;
    logic [15:0] errCount;
    logic [5:0]  firstX;
    logic [7:0]  firstY;

    int totalCount = 0;
    int badCount   = 0;
    int cycleNo    = 0;

    typedef struct {
        logic        mm;
        logic        se;
        logic        fd;
        logic        rdy;
        logic        fok;
        logic [15:0] cnt;
        logic [5:0]  fx;
        logic [7:0]  fy;
    } exp_t;

    exp_t sbQueue[$];

    bit mActive  = 0;
    bit mReport  = 0;
    bit mRunOk   = 0;
    bit mFrameOk = 0;
    int mPos     = 0;
    int mErr     = 0;
    int mFirstX  = 0;
    int mFirstY  = 0;

    test_card_gradient_checker #(.H_RES(H), .V_RES(V)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_sof         (sof),
        .i_red         (red),
        .i_green       (green),
        .i_blue        (blue),
        .o_ready       (ready),
        .o_mismatch    (mismatch),
        .o_sync_err    (syncErr),
        .o_frame_done  (frameDone),
        .o_frame_ok    (frameOk),
        .o_err_count   (errCount),
        .o_first_err_x (firstX),
        .o_first_err_y (firstY)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cycleNo);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference gradient written straight from the colour equations.
    function automatic logic [23:0] grad_colour(input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'((x + y) % 256);
        g = 8'((16 + y) % 256);
        b = 8'((76 + y) % 256);
        return {r, g, b};
    endfunction

    // One clock: check last cycle's prediction, drive, advance the model, predict.
    task automatic drive_cycle(input logic rstIn, input logic validIn, input logic sofIn,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        int px, py;
        logic [23:0] want;
        @(negedge clk);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            totalCount += 8;
            if (mismatch  !== e.mm)  begin badCount++; $display("[TB] FAIL sb_mismatch cycle=%0d got=%b want=%b", cycleNo, mismatch, e.mm); end
            if (syncErr   !== e.se)  begin badCount++; $display("[TB] FAIL sb_sync_err cycle=%0d got=%b want=%b", cycleNo, syncErr, e.se); end
            if (frameDone !== e.fd)  begin badCount++; $display("[TB] FAIL sb_frame_done cycle=%0d got=%b want=%b", cycleNo, frameDone, e.fd); end
            if (ready     !== e.rdy) begin badCount++; $display("[TB] FAIL sb_ready cycle=%0d got=%b want=%b", cycleNo, ready, e.rdy); end
            if (frameOk   !== e.fok) begin badCount++; $display("[TB] FAIL sb_frame_ok cycle=%0d got=%b want=%b", cycleNo, frameOk, e.fok); end
            if (errCount  !== e.cnt) begin badCount++; $display("[TB] FAIL sb_err_count cycle=%0d got=%h want=%h", cycleNo, errCount, e.cnt); end
            if (firstX    !== e.fx)  begin badCount++; $display("[TB] FAIL sb_first_x cycle=%0d got=%0d want=%0d", cycleNo, firstX, e.fx); end
            if (firstY    !== e.fy)  begin badCount++; $display("[TB] FAIL sb_first_y cycle=%0d got=%0d want=%0d", cycleNo, firstY, e.fy); end
        end
        rst   = rstIn;
        valid = validIn;
        sof   = sofIn;
        red   = r;
        green = g;
        blue  = b;
        @(posedge clk);
        cycleNo++;
        e.mm = 1'b0;
        e.se = 1'b0;
        e.fd = 1'b0;
        if (rstIn) begin
            mActive  = 0;
            mReport  = 0;
            mPos     = 0;
            mErr     = 0;
            mFirstX  = 0;
            mFirstY  = 0;
            mFrameOk = 0;
        end else if (mReport) begin
            mReport = 0;
        end else if (validIn) begin
            if (sofIn) begin
                if (mActive) begin
                    e.se   = 1'b1;
                    mRunOk = 0;
                end else begin
                    mErr    = 0;
                    mFirstX = 0;
                    mFirstY = 0;
                    mRunOk  = 1;
                end
                mActive = 1;
                mPos    = 0;
            end
            if (mActive) begin
                px   = mPos % H;
                py   = mPos / H;
                want = grad_colour(px, py);
                if ({r, g, b} != want) begin
                    e.mm   = 1'b1;
                    mRunOk = 0;
                    if (mErr == 0) begin
                        mFirstX = px;
                        mFirstY = py;
                    end
                    if (mErr < 65535) mErr++;
                end
                mPos++;
                if (mPos == FRAME) begin
                    e.fd     = 1'b1;
                    mFrameOk = mRunOk;
                    mReport  = 1;
                    mActive  = 0;
                    mPos     = 0;
                end
            end
        end
        e.rdy = !mReport;
        e.fok = mFrameOk;
        e.cnt = 16'(mErr);
        e.fx  = 6'(mFirstX);
        e.fy  = 8'(mFirstY);
        sbQueue.push_back(e);
    endtask

    // Correct beat for the model's current position (or (0,0) for a sof beat).
    task automatic send_good(input logic sofIn);
        int p;
        logic [23:0] c;
        p = sofIn ? 0 : mPos;
        c = grad_colour(p % H, p / H);
        drive_cycle(1'b0, 1'b1, sofIn, c[23:16], c[15:8], c[7:0]);
    endtask

    // Beat whose red channel is off by one bit.
    task automatic send_bad(input logic sofIn);
        int p;
        logic [23:0] c;
        p = sofIn ? 0 : mPos;
        c = grad_colour(p % H, p / H);
        drive_cycle(1'b0, 1'b1, sofIn, c[23:16] ^ 8'h01, c[15:8], c[7:0]);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #2;
        totalCount += 5;
        if (ready !== 1'b1)      begin badCount++; $display("[TB] FAIL reset_ready got=%b want=1", ready); end
        if (errCount !== 16'd0)  begin badCount++; $display("[TB] FAIL reset_err_count got=%h want=0", errCount); end
        if (frameOk !== 1'b0)    begin badCount++; $display("[TB] FAIL reset_frame_ok got=%b want=0", frameOk); end
        if (frameDone !== 1'b0)  begin badCount++; $display("[TB] FAIL reset_frame_done got=%b want=0", frameDone); end
        if ({firstX, firstY} !== 14'd0) begin badCount++; $display("[TB] FAIL reset_first_err got=(%0d,%0d) want=(0,0)", firstX, firstY); end
        drive_cycle(1'b0, 1'b1, 1'b0, 8'hAA, 8'h55, 8'h33);
        #2;
        totalCount += 1;
        if (mismatch !== 1'b0)   begin badCount++; $display("[TB] FAIL idle_discard got=%b want=0", mismatch); end
    endtask

    task automatic test_clean_frame();
        send_good(1'b1);
        repeat (FRAME - 1) send_good(1'b0);
        #2;
        totalCount += 4;
        if (frameDone !== 1'b1)  begin badCount++; $display("[TB] FAIL clean_done got=%b want=1", frameDone); end
        if (frameOk !== 1'b1)    begin badCount++; $display("[TB] FAIL clean_ok got=%b want=1", frameOk); end
        if (errCount !== 16'd0)  begin badCount++; $display("[TB] FAIL clean_err_count got=%h want=0", errCount); end
        if (ready !== 1'b0)      begin badCount++; $display("[TB] FAIL clean_report_ready got=%b want=0", ready); end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #2;
        totalCount += 2;
        if (ready !== 1'b1)      begin badCount++; $display("[TB] FAIL clean_ready_back got=%b want=1", ready); end
        if (frameDone !== 1'b0)  begin badCount++; $display("[TB] FAIL clean_done_once got=%b want=0", frameDone); end
    endtask

    task automatic test_corrupt_pixel();
        send_good(1'b1);
        while (mPos != 3 * H + 5) send_good(1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h09, 8'h13, 8'h4F);
        #2;
        totalCount += 3;
        if (mismatch !== 1'b1)   begin badCount++; $display("[TB] FAIL corrupt_pulse got=%b want=1", mismatch); end
        if (errCount !== 16'd1)  begin badCount++; $display("[TB] FAIL corrupt_count got=%h want=1", errCount); end
        if (firstX !== 6'd5 || firstY !== 8'd3) begin badCount++; $display("[TB] FAIL corrupt_first got=(%0d,%0d) want=(5,3)", firstX, firstY); end
        while (mPos != 7 * H + 10) send_good(1'b0);
    endtask

    task automatic test_mid_sof();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 8'h4C);
        #2;
        totalCount += 3;
        if (syncErr !== 1'b1)    begin badCount++; $display("[TB] FAIL midsof_pulse got=%b want=1", syncErr); end
        if (mismatch !== 1'b0)   begin badCount++; $display("[TB] FAIL midsof_as_origin got=%b want=0", mismatch); end
        if (errCount !== 16'd1)  begin badCount++; $display("[TB] FAIL midsof_count_kept got=%h want=1", errCount); end
        while (mPos != FRAME - 40) send_good(1'b0);
    endtask

    task automatic test_wrap();
        while (mPos != FRAME - 1) begin
            repeat ($urandom_range(0, 3)) drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            send_good(1'b0);
        end
        repeat ($urandom_range(1, 3)) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h3E, 8'h0F, 8'h4B);
        #2;
        totalCount += 6;
        if (mismatch !== 1'b0)   begin badCount++; $display("[TB] FAIL wrap_no_mismatch got=%b want=0", mismatch); end
        if (frameDone !== 1'b1)  begin badCount++; $display("[TB] FAIL wrap_done got=%b want=1", frameDone); end
        if (ready !== 1'b0)      begin badCount++; $display("[TB] FAIL wrap_report_ready got=%b want=0", ready); end
        if (frameOk !== 1'b0)    begin badCount++; $display("[TB] FAIL wrap_resync_ok got=%b want=0", frameOk); end
        if (errCount !== 16'd1)  begin badCount++; $display("[TB] FAIL wrap_count got=%h want=1", errCount); end
        if (firstX !== 6'd5 || firstY !== 8'd3) begin badCount++; $display("[TB] FAIL wrap_first got=(%0d,%0d) want=(5,3)", firstX, firstY); end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #2;
        totalCount += 1;
        if (ready !== 1'b1)      begin badCount++; $display("[TB] FAIL wrap_report_one_cycle got=%b want=1", ready); end
    endtask

    task automatic test_saturation();
        int sent;
        send_bad(1'b1);
        sent = 1;
        while (!(mPos == 100 * H + 20 && sent >= 65600) && sent < 90000) begin
            send_bad(mPos == 232 * H);
            sent++;
        end
        #2;
        totalCount += 2;
        if (errCount !== 16'hFFFF) begin badCount++; $display("[TB] FAIL sat_hold got=%h want=ffff", errCount); end
        if (mismatch !== 1'b1)   begin badCount++; $display("[TB] FAIL sat_pulse got=%b want=1", mismatch); end
    endtask

    task automatic test_reset_mid_frame();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        #2;
        totalCount += 6;
        if (frameDone !== 1'b0)  begin badCount++; $display("[TB] FAIL rstmid_no_done got=%b want=0", frameDone); end
        if (mismatch !== 1'b0)   begin badCount++; $display("[TB] FAIL rstmid_mismatch got=%b want=0", mismatch); end
        if (errCount !== 16'd0)  begin badCount++; $display("[TB] FAIL rstmid_count got=%h want=0", errCount); end
        if (ready !== 1'b1)      begin badCount++; $display("[TB] FAIL rstmid_ready got=%b want=1", ready); end
        if (syncErr !== 1'b0)    begin badCount++; $display("[TB] FAIL rstmid_sync got=%b want=0", syncErr); end
        if ({firstX, firstY} !== 14'd0) begin badCount++; $display("[TB] FAIL rstmid_first got=(%0d,%0d) want=(0,0)", firstX, firstY); end
        repeat (4) send_bad(1'b0);
        #2;
        totalCount += 2;
        if (mismatch !== 1'b0)   begin badCount++; $display("[TB] FAIL rstmid_discard got=%b want=0", mismatch); end
        if (errCount !== 16'd0)  begin badCount++; $display("[TB] FAIL rstmid_discard_count got=%h want=0", errCount); end
        send_good(1'b1);
        send_bad(1'b0);
        #2;
        totalCount += 4;
        if (mismatch !== 1'b1)   begin badCount++; $display("[TB] FAIL restart_pulse got=%b want=1", mismatch); end
        if (errCount !== 16'd1)  begin badCount++; $display("[TB] FAIL restart_count got=%h want=1", errCount); end
        if (firstX !== 6'd1 || firstY !== 8'd0) begin badCount++; $display("[TB] FAIL restart_first got=(%0d,%0d) want=(1,0)", firstX, firstY); end
        if (syncErr !== 1'b0)    begin badCount++; $display("[TB] FAIL restart_sync got=%b want=0", syncErr); end
    endtask

    // Scenario sequence.
    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        sof   = 1'b0;
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
        test_reset();
        test_clean_frame();
        test_corrupt_pixel();
        test_mid_sof();
        test_wrap();
        test_saturation();
        test_reset_mid_frame();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
